// File: rtl/fod_ctrl_pkg.sv
// Shared types and constants for the fractional output divider control sequencer.
package fod_ctrl_pkg;

  localparam int WI_DEF      = 6;
  localparam int WF_DEF      = 16;
  localparam int FCW_INT_MIN = 4;

  localparam logic [WI_DEF+WF_DEF-1:0] FCW_RST = {6'd4, 16'd0};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WARM  = 3'd2,
    ST_PSYNC = 3'd3,
    ST_INL   = 3'd4,
    ST_TRACK = 3'd5,
    ST_FAULT = 3'd6
  } state_t;

endpackage

// File: rtl/fod_seq_ctrl_if.sv
// Control/status bundle between the sequencer and its host.
// Handshake: an FCW transfers on a rising clk edge where i_fcw_valid and o_fcw_ready
// are both high; o_fcw_ready depends on the sequencer state only.
interface fod_seq_ctrl_if
  import fod_ctrl_pkg::*;
#(
  parameter int WI = WI_DEF,
  parameter int WF = WF_DEF
);
  logic                 i_start;
  logic                 i_abort;
  logic                 i_fcw_valid;
  logic [WI+WF-1:0]     i_fcw_in;
  logic [WF-1:0]        i_phe_norm;
  logic                 o_fcw_ready;
  logic [WI+WF-1:0]     o_fcw_fod;
  logic                 o_dsm_en;
  logic                 o_psync_en;
  logic                 o_inl_cali_en;
  logic                 o_locked;
  logic                 o_err_range;
  logic                 o_timeout;
  logic [7:0]           o_relock_cnt;
  logic [2:0]           o_state;

  modport slave (
    input  i_start, i_abort, i_fcw_valid, i_fcw_in, i_phe_norm,
    output o_fcw_ready, o_fcw_fod, o_dsm_en, o_psync_en, o_inl_cali_en,
           o_locked, o_err_range, o_timeout, o_relock_cnt, o_state
  );

  modport master (
    output i_start, i_abort, i_fcw_valid, i_fcw_in, i_phe_norm,
    input  o_fcw_ready, o_fcw_fod, o_dsm_en, o_psync_en, o_inl_cali_en,
           o_locked, o_err_range, o_timeout, o_relock_cnt, o_state
  );
endinterface

// File: rtl/fod_lock_det.sv
// Phase-error magnitude qualifier: pulses o_hit on the CNT-th consecutive qualifying sample.
module fod_lock_det #(
  parameter int WF  = 16,
  parameter int CNT = 256
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [WF-1:0] i_phe,
  input  logic [WF-1:0] i_thr,
  input  logic          i_above,
  input  logic          i_en,
  input  logic          i_clr,
  output logic          o_hit
);

  localparam int CW = $clog2(CNT + 1);

  logic [CW-1:0] r_cnt;
  logic [WF-1:0] w_neg;
  logic [WF-1:0] w_mag;
  logic          w_qual;
  logic          w_hit;

  assign w_neg = (~i_phe) + {{(WF-1){1'b0}}, 1'b1};

  // The most negative code has no positive twin; clamp it to the largest magnitude.
  always_comb begin
    w_mag = i_phe;
    if (i_phe[WF-1]) begin
      if (i_phe == {1'b1, {(WF-1){1'b0}}}) w_mag = {1'b0, {(WF-1){1'b1}}};
      else                                 w_mag = w_neg;
    end
  end

  assign w_qual = i_above ? (w_mag >= i_thr) : (w_mag < i_thr);
  assign w_hit  = i_en && w_qual && (r_cnt == CW'(CNT - 1));
  assign o_hit  = w_hit;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr || !i_en || !w_qual || w_hit) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/fod_seq_ctrl.sv
// Startup/retune sequencer: FCW load, DSM warm-up, phase-sync acquisition,
// DTC INL calibration and locked tracking with loss-of-lock detection.
module fod_seq_ctrl
  import fod_ctrl_pkg::*;
#(
  parameter int WI          = WI_DEF,
  parameter int WF          = WF_DEF,
  parameter int T_SETTLE    = 64,
  parameter int T_PSYNC_MAX = 65535,
  parameter int T_INL       = 4096,
  parameter int LOCK_THR    = 64,
  parameter int UNLOCK_THR  = 512,
  parameter int LOCK_CNT    = 256
) (
  input  logic           i_clk,
  input  logic           i_rst,
  fod_seq_ctrl_if.slave  bus
);

  localparam logic [WI+WF-1:0] L_FCW_RST  = {WI'(FCW_INT_MIN), WF'(0)};
  localparam logic [15:0]      L_T_WARM   = 16'(T_SETTLE - 1);
  localparam logic [15:0]      L_T_PSYNC  = 16'(T_PSYNC_MAX - 1);
  localparam logic [15:0]      L_T_INL    = 16'(T_INL - 1);
  localparam logic [WF-1:0]    L_LOCK_THR = WF'(LOCK_THR);
  localparam logic [WF-1:0]    L_UNL_THR  = WF'(UNLOCK_THR);

  state_t           r_state;
  logic [WI+WF-1:0] r_fcw;
  logic [15:0]      r_timer;
  logic             r_timeout;
  logic             r_err;
  logic [7:0]       r_relock;

  logic w_ready;
  logic w_fcw_acc;
  logic w_fcw_ok;
  logic w_fcw_load;
  logic w_start;
  logic w_tmo;
  logic w_det_en;
  logic w_det_clr;
  logic w_hit;

  assign w_ready    = (r_state == ST_IDLE) || (r_state == ST_TRACK) || (r_state == ST_FAULT);
  assign w_fcw_acc  = bus.i_fcw_valid && w_ready;
  assign w_fcw_ok   = bus.i_fcw_in[WI+WF-1:WF] >= WI'(FCW_INT_MIN);
  assign w_fcw_load = w_fcw_acc && w_fcw_ok && !bus.i_abort;
  assign w_start    = bus.i_start && ((r_state == ST_IDLE) || (r_state == ST_FAULT));
  assign w_tmo      = (r_state == ST_PSYNC) && (r_timer == 16'd0);
  assign w_det_en   = (r_state == ST_PSYNC) || (r_state == ST_TRACK);
  // Exits from PSYNC/TRACK not signalled by the detector itself must restart its run.
  assign w_det_clr  = bus.i_abort || w_fcw_load || w_tmo;

  fod_lock_det #(
    .WF  (WF),
    .CNT (LOCK_CNT)
  ) u_lock_det (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_phe   (bus.i_phe_norm),
    .i_thr   ((r_state == ST_TRACK) ? L_UNL_THR : L_LOCK_THR),
    .i_above (r_state == ST_TRACK),
    .i_en    (w_det_en),
    .i_clr   (w_det_clr),
    .o_hit   (w_hit)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_fcw     <= L_FCW_RST;
      r_timer   <= '0;
      r_timeout <= 1'b0;
      r_err     <= 1'b0;
      r_relock  <= '0;
    end else begin
      r_err <= 1'b0;
      if (bus.i_abort) begin
        r_state <= ST_IDLE;
      end else if (w_fcw_acc) begin
        if (w_fcw_ok) begin
          r_fcw     <= bus.i_fcw_in;
          r_state   <= ST_LOAD;
          r_timeout <= 1'b0;
        end else begin
          r_err <= 1'b1;
        end
      end else if (w_start) begin
        r_state   <= ST_LOAD;
        r_timeout <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE, ST_FAULT: r_state <= r_state;
          ST_LOAD: begin
            r_state <= ST_WARM;
            r_timer <= L_T_WARM;
          end
          ST_WARM: begin
            if (r_timer == 16'd0) begin
              r_state <= ST_PSYNC;
              r_timer <= L_T_PSYNC;
            end else begin
              r_timer <= r_timer - 16'd1;
            end
          end
          // A lock hit on the final timeout cycle still wins.
          ST_PSYNC: begin
            if (w_hit) begin
              r_state <= ST_INL;
              r_timer <= L_T_INL;
            end else if (w_tmo) begin
              r_state   <= ST_FAULT;
              r_timeout <= 1'b1;
            end else begin
              r_timer <= r_timer - 16'd1;
            end
          end
          ST_INL: begin
            if (r_timer == 16'd0) r_state <= ST_TRACK;
            else                  r_timer <= r_timer - 16'd1;
          end
          ST_TRACK: begin
            if (w_hit) begin
              r_state <= ST_PSYNC;
              r_timer <= L_T_PSYNC;
              if (r_relock != 8'hFF) r_relock <= r_relock + 8'd1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.o_fcw_ready   = w_ready;
  assign bus.o_fcw_fod     = r_fcw;
  assign bus.o_dsm_en      = (r_state == ST_WARM) || (r_state == ST_PSYNC) || (r_state == ST_INL) ||
                             (r_state == ST_TRACK) || (r_state == ST_FAULT);
  assign bus.o_psync_en    = (r_state == ST_PSYNC) || (r_state == ST_INL) || (r_state == ST_TRACK);
  assign bus.o_inl_cali_en = (r_state == ST_INL) || (r_state == ST_TRACK);
  assign bus.o_locked      = (r_state == ST_TRACK);
  assign bus.o_err_range   = r_err;
  assign bus.o_timeout     = r_timeout;
  assign bus.o_relock_cnt  = r_relock;
  assign bus.o_state       = r_state;

endmodule

// File: tb/tb_fod_seq_ctrl.sv
// Randomized scoreboard bench for fod_seq_ctrl: a reference model predicts every
// state transition (with dwell time and output snapshot) and every range-error pulse.
module tb_fod_seq_ctrl;
  import fod_ctrl_pkg::*;

  localparam int T_SETTLE    = 16;
  localparam int T_PSYNC_MAX = 1000;
  localparam int T_INL       = 32;
  localparam int LOCK_CNT    = 8;
  localparam int LOCK_THR    = 64;
  localparam int UNLOCK_THR  = 512;
  localparam logic [15:0] DC = 16'hFFFF;

  typedef struct packed {
    logic [2:0]  st;
    logic [15:0] dur;
    logic [21:0] fcw;
    logic        dsm;
    logic        ps;
    logic        inl;
    logic        lk;
    logic        to;
    logic [7:0]  rc;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fod_seq_ctrl_if #(.WI(6), .WF(16)) bus ();

  fod_seq_ctrl #(
    .WI(6), .WF(16), .T_SETTLE(T_SETTLE), .T_PSYNC_MAX(T_PSYNC_MAX), .T_INL(T_INL),
    .LOCK_THR(LOCK_THR), .UNLOCK_THR(UNLOCK_THR), .LOCK_CNT(LOCK_CNT)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [53:0] exp_q[$];
  logic [24:0] err_q[$];

  logic signed [15:0] ps_arr[1024];
  int                 ps_n = 0;
  logic signed [15:0] tr_arr[64];
  int                 tr_n = 0;
  bit                 tr_armed = 1'b0;

  // ---------------- reference model ----------------
  function automatic int mag(input int v);
    if (v == -32768) return 32767;
    return (v < 0) ? -v : v;
  endfunction

  function automatic int ps_val(input int i);
    return (i < ps_n) ? int'(ps_arr[i]) : 0;
  endfunction

  function automatic int tr_val(input int i);
    return (i < tr_n) ? int'(tr_arr[i]) : 0;
  endfunction

  function automatic int psync_cycles();
    int run = 0;
    for (int i = 0; i < T_PSYNC_MAX; i++) begin
      if (mag(ps_val(i)) < LOCK_THR) run++; else run = 0;
      if (run == LOCK_CNT) return i + 1;
    end
    return -1;
  endfunction

  function automatic int track_cycles();
    int run = 0;
    for (int i = 0; i < 64; i++) begin
      if (mag(tr_val(i)) >= UNLOCK_THR) run++; else run = 0;
      if (run == LOCK_CNT) return i + 1;
    end
    return -1;
  endfunction

  function automatic logic [53:0] mk(input logic [2:0] st, input logic [15:0] dur,
                                     input logic [21:0] fcw, input logic [4:0] flags,
                                     input int rc);
    ev_t e;
    e.st = st; e.dur = dur; e.fcw = fcw;
    {e.dsm, e.ps, e.inl, e.lk, e.to} = flags;
    e.rc = 8'(rc);
    return e;
  endfunction

  task automatic expect_run(input logic [21:0] fcw, input bit armed, inout int rc);
    int  l, u;
    bit  arm  = armed;
    bit  done = 1'b0;
    exp_q.push_back(mk(ST_LOAD,  DC,               fcw, 5'b00000, rc));
    exp_q.push_back(mk(ST_WARM,  16'd1,            fcw, 5'b10000, rc));
    exp_q.push_back(mk(ST_PSYNC, 16'(T_SETTLE),    fcw, 5'b11000, rc));
    while (!done) begin
      l = psync_cycles();
      if (l < 0) begin
        exp_q.push_back(mk(ST_FAULT, 16'(T_PSYNC_MAX), fcw, 5'b10001, rc));
        done = 1'b1;
      end else begin
        exp_q.push_back(mk(ST_INL,   16'(l),     fcw, 5'b11100, rc));
        exp_q.push_back(mk(ST_TRACK, 16'(T_INL), fcw, 5'b11110, rc));
        u = arm ? track_cycles() : -1;
        if (u < 0) begin
          done = 1'b1;
        end else begin
          arm = 1'b0;
          if (rc < 255) rc++;
          exp_q.push_back(mk(ST_PSYNC, 16'(u), fcw, 5'b11000, rc));
        end
      end
    end
  endtask

  // ---------------- phase-error source ----------------
  logic [2:0] src_last = 3'd0;
  int ps_i = 0;
  int tr_i = 0;
  always @(negedge clk) begin
    if (bus.o_state == ST_PSYNC) begin
      if (src_last != ST_PSYNC) ps_i = 0;
      bus.i_phe_norm = 16'(ps_val(ps_i));
      ps_i++;
    end else if (bus.o_state == ST_TRACK) begin
      if (src_last != ST_TRACK) tr_i = 0;
      bus.i_phe_norm = tr_armed ? 16'(tr_val(tr_i)) : 16'd0;
      tr_i++;
    end else begin
      bus.i_phe_norm = 16'd0;
    end
    if (src_last == ST_TRACK && bus.o_state != ST_TRACK) tr_armed = 1'b0;
    src_last = bus.o_state;
  end

  // ---------------- monitor / scoreboard ----------------
  logic [2:0] mon_last = 3'd0;
  int         mon_dur  = 0;
  always @(negedge clk) begin
    ev_t act, exp_e;
    logic [24:0] e_err;
    if (!rst) begin
      if (bus.o_err_range) begin
        n_chk++;
        if (err_q.size() == 0) begin
          n_fail++;
          $display("FAIL err_range: got unexpected pulse in state %0d, required none", bus.o_state);
        end else begin
          e_err = err_q.pop_front();
          if ({bus.o_state, bus.o_fcw_fod} !== e_err) begin
            n_fail++;
            $display("FAIL err_range_ctx: got {state,fcw}=0x%0h required 0x%0h",
                     {bus.o_state, bus.o_fcw_fod}, e_err);
          end
        end
      end
      if (bus.o_state != mon_last) begin
        act = mk(bus.o_state, 16'(mon_dur), bus.o_fcw_fod,
                 {bus.o_dsm_en, bus.o_psync_en, bus.o_inl_cali_en, bus.o_locked, bus.o_timeout},
                 int'(bus.o_relock_cnt));
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL transition: got unexpected event 0x%0h (state %0d), required none", act, act.st);
        end else begin
          exp_e = exp_q.pop_front();
          if (exp_e.dur == DC) act.dur = DC;
          if (act !== exp_e) begin
            n_fail++;
            $display("FAIL transition: got st=%0d dur=%0d fcw=%h en=%b%b%b lk=%b to=%b rc=%0d, required st=%0d dur=%0d fcw=%h en=%b%b%b lk=%b to=%b rc=%0d",
                     act.st, act.dur, act.fcw, act.dsm, act.ps, act.inl, act.lk, act.to, act.rc,
                     exp_e.st, exp_e.dur, exp_e.fcw, exp_e.dsm, exp_e.ps, exp_e.inl, exp_e.lk, exp_e.to, exp_e.rc);
          end
        end
        mon_dur  = 1;
        mon_last = bus.o_state;
      end else begin
        mon_dur++;
      end
    end
  end

  // ---------------- checks and drivers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp_v);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_state",   32'(bus.o_state),       32'd0);
    chk("rst_fcw",     32'(bus.o_fcw_fod),     32'(FCW_RST));
    chk("rst_dsm",     32'(bus.o_dsm_en),      32'd0);
    chk("rst_psync",   32'(bus.o_psync_en),    32'd0);
    chk("rst_inl",     32'(bus.o_inl_cali_en), 32'd0);
    chk("rst_locked",  32'(bus.o_locked),      32'd0);
    chk("rst_err",     32'(bus.o_err_range),   32'd0);
    chk("rst_timeout", 32'(bus.o_timeout),     32'd0);
    chk("rst_relock",  32'(bus.o_relock_cnt),  32'd0);
    chk("rst_ready",   32'(bus.o_fcw_ready),   32'd1);
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (bus.o_state !== s && k < budget);
    chk("wait_state", 32'(bus.o_state), 32'(s));
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (exp_q.size() != 0 && k < budget);
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic drive_fcw(input logic [21:0] w);
    @(negedge clk);
    bus.i_fcw_valid = 1'b1;
    bus.i_fcw_in    = w;
    @(negedge clk);
    bus.i_fcw_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  function automatic logic [21:0] rand_fcw();
    return {6'($urandom_range(4, 63)), 16'($urandom)};
  endfunction

  function automatic logic signed [15:0] rand_big();
    logic signed [15:0] v;
    if ($urandom_range(0, 3) == 0) v = 16'sh8000;
    else v = 16'($urandom_range(UNLOCK_THR, 32767));
    if ($urandom_range(0, 1) == 1) v = -v;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, required end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc = 0;
    logic [21:0] f;
    bus.i_start     = 1'b0;
    bus.i_abort     = 1'b0;
    bus.i_fcw_valid = 1'b0;
    bus.i_fcw_in    = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst = 1'b0;

    // Out-of-range integer part offered in IDLE
    err_q.push_back({3'(ST_IDLE), FCW_RST});
    drive_fcw({6'd3, 16'($urandom)});
    repeat (3) @(negedge clk);
    chk("reject_state", 32'(bus.o_state),   32'(ST_IDLE));
    chk("reject_fcw",   32'(bus.o_fcw_fod), 32'(FCW_RST));

    // Nominal bring-up with zero phase error; 7-cycle excursion must not unlock
    ps_n = 0;
    tr_n = 0;
    for (int i = 0; i < 7; i++) tr_arr[tr_n++] = -16'sd600;
    for (int i = 0; i < 20; i++) tr_arr[tr_n++] = 16'sd0;
    tr_armed = 1'b1;
    expect_run({6'd10, 16'h8000}, 1'b1, rc);
    drive_fcw({6'd10, 16'h8000});
    wait_state(ST_TRACK, 200);
    err_q.push_back({3'(ST_TRACK), 22'h0A8000});
    drive_fcw({6'($urandom_range(0, 3)), 16'($urandom)});
    repeat (30) @(negedge clk);
    chk("track_locked", 32'(bus.o_locked),      32'd1);
    chk("track_fcw",    32'(bus.o_fcw_fod),     32'h0A8000);
    chk("track_inl",    32'(bus.o_inl_cali_en), 32'd1);
    chk("track_relock", 32'(bus.o_relock_cnt),  32'd0);

    // Retune from TRACK with random phase error, then a loss-of-lock burst
    tr_armed = 1'b0;
    ps_n = 1024;
    for (int i = 0; i < 1024; i++) begin
      if ($urandom_range(0, 3) != 0) ps_arr[i] = 16'($signed($urandom_range(0, 126)) - 63);
      else ps_arr[i] = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(LOCK_THR, 2000))
                                                   : -16'($urandom_range(LOCK_THR, 2000));
    end
    tr_n = 0;
    for (int i = 0, n = $urandom_range(0, 6); i < n; i++) tr_arr[tr_n++] = 16'($signed($urandom_range(0, 1022)) - 511);
    for (int i = 0; i < 7; i++) tr_arr[tr_n++] = -16'sd600;
    tr_arr[tr_n++] = 16'sd0;
    for (int i = 0; i < LOCK_CNT; i++) tr_arr[tr_n++] = rand_big();
    f = rand_fcw();
    expect_run(f, 1'b1, rc);
    drive_fcw(f);
    wait_state(ST_WARM, 10);
    tr_armed = 1'b1;
    wait_drain(5000);
    chk("unlock_relock", 32'(bus.o_relock_cnt), 32'(rc));

    // Phase sync never settles -> FAULT with TIMEOUT, then START recovers
    tr_armed = 1'b0;
    ps_n = 1024;
    for (int i = 0; i < 1024; i++) ps_arr[i] = (i % 2 == 0) ? 16'sd10 : 16'sd100;
    f = rand_fcw();
    expect_run(f, 1'b0, rc);
    drive_fcw(f);
    wait_drain(1500);
    chk("fault_state",   32'(bus.o_state),    32'(ST_FAULT));
    chk("fault_timeout", 32'(bus.o_timeout),  32'd1);
    chk("fault_psync",   32'(bus.o_psync_en), 32'd0);
    chk("fault_ready",   32'(bus.o_fcw_ready), 32'd1);
    ps_n = 0;
    expect_run(f, 1'b0, rc);
    pulse_start();
    wait_drain(500);
    chk("restart_timeout", 32'(bus.o_timeout), 32'd0);

    // ABORT together with FCW_VALID (and START) during WARM
    f = rand_fcw();
    exp_q.push_back(mk(ST_LOAD, DC,    f, 5'b00000, rc));
    exp_q.push_back(mk(ST_WARM, 16'd1, f, 5'b10000, rc));
    exp_q.push_back(mk(ST_IDLE, DC,    f, 5'b00000, rc));
    drive_fcw(f);
    wait_state(ST_WARM, 10);
    repeat ($urandom_range(0, 10)) @(negedge clk);
    @(negedge clk);
    bus.i_abort = 1'b1; bus.i_fcw_valid = 1'b1; bus.i_start = 1'b1; bus.i_fcw_in = rand_fcw();
    @(negedge clk);
    bus.i_abort = 1'b0; bus.i_fcw_valid = 1'b0; bus.i_start = 1'b0;
    wait_drain(50);
    chk("abort_fcw",   32'(bus.o_fcw_fod), 32'(f));
    chk("abort_state", 32'(bus.o_state),   32'(ST_IDLE));
    chk("abort_dsm",   32'(bus.o_dsm_en),  32'd0);

    // Asynchronous reset in the middle of INL, then a full run from the reset FCW
    exp_q.push_back(mk(ST_LOAD,  DC,               f, 5'b00000, rc));
    exp_q.push_back(mk(ST_WARM,  16'd1,            f, 5'b10000, rc));
    exp_q.push_back(mk(ST_PSYNC, 16'(T_SETTLE),    f, 5'b11000, rc));
    exp_q.push_back(mk(ST_INL,   16'(LOCK_CNT),    f, 5'b11100, rc));
    exp_q.push_back(mk(ST_IDLE,  DC,         FCW_RST, 5'b00000, 0));
    pulse_start();
    wait_state(ST_INL, 100);
    repeat ($urandom_range(1, 20)) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_outputs();
    #1 rst = 1'b0;
    rc = 0;
    expect_run(FCW_RST, 1'b0, rc);
    pulse_start();
    wait_drain(500);
    chk("final_locked", 32'(bus.o_locked),  32'd1);
    chk("final_fcw",    32'(bus.o_fcw_fod), 32'(FCW_RST));

    repeat (3) @(negedge clk);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    chk("err_q_empty", 32'(err_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fod_seq_ctrl.md
# fod_seq_ctrl

Startup and retune sequencer for the fractional output divider control path. It accepts new frequency control words (FCW) over a valid/ready handshake and applies them glitch-free. It then walks the divider control through DSM warm-up, phase-sync acquisition, DTC INL calibration and locked tracking. It drives the DSM enable, the phase-sync and INL calibration enables and the applied FCW, and it monitors the normalized phase error to decide when lock has been gained or lost.

## Interface
- WI, 6, FCW integer bits
- WF, 16, FCW fractional bits; also the PHE_NORM width
- T_SETTLE, 64, DSM warm-up cycles (1..65535)
- T_PSYNC_MAX, 65535, phase-sync acquisition timeout in cycles
- T_INL, 4096, INL calibration window in cycles
- LOCK_THR, 64, lock threshold on |PHE_NORM| (LSB = 2^-WF)
- UNLOCK_THR, 512, loss-of-lock threshold on |PHE_NORM|
- LOCK_CNT, 256, consecutive qualifying cycles needed for a lock or unlock decision

- CLK  in  1  sole clock
- RST  in  1  asynchronous, active-high reset
- START  in  1  in IDLE or FAULT, begin a sequence with the held FCW
- ABORT  in  1  return to IDLE from any state
- FCW_VALID  in  1  new FCW offered
- FCW_IN  in  WI+WF  offered FCW, unsigned, integer part 4..63
- FCW_READY  out  1  high in IDLE, TRACK and FAULT
- PHE_NORM  in  WF  signed normalized phase error from phase sync
- FCW_FOD  out  WI+WF  applied FCW; reset value {6'd4, 16'd0}
- DSM_EN  out  1  DSM accumulate enable; reset 0
- PSYNC_EN  out  1  phase-sync loop enable; reset 0
- INL_CALI_EN  out  1  DTC INL calibration enable; reset 0
- LOCKED  out  1  reset 0
- ERR_RANGE  out  1  one-cycle pulse when an FCW is rejected; reset 0
- TIMEOUT  out  1  sticky; cleared by START or an accepted FCW; reset 0
- RELOCK_CNT  out  8  saturating count of loss-of-lock events; reset 0
- STATE  out  3  current state encoding; reset 0

## Operation
- States: IDLE=0, LOAD=1, WARM=2, PSYNC=3, INL=4, TRACK=5, FAULT=6. Code 7 is illegal and recovers to IDLE.
- An FCW is accepted when FCW_VALID and FCW_READY are both high.
  - If FCW_IN[WI+WF-1:WF] < 4, the word is not stored. ERR_RANGE pulses and the state is unchanged.
  - Otherwise FCW_FOD takes FCW_IN at the accept edge, the state goes to LOAD, and TIMEOUT clears.
- START in IDLE or FAULT goes to LOAD with FCW_FOD unchanged and clears TIMEOUT. START in any other state is ignored.
- LOAD: lasts 1 cycle with DSM_EN=0, which freezes the MMD carry while the integer part changes. Goes to WARM.
- WARM: DSM_EN=1 for exactly T_SETTLE cycles, then PSYNC.
- PSYNC: DSM_EN=1, PSYNC_EN=1.
  - Goes to INL when LOCK_CNT consecutive cycles each have |PHE_NORM| < LOCK_THR.
  - If T_PSYNC_MAX cycles pass first, goes to FAULT and sets TIMEOUT.
- INL: DSM_EN, PSYNC_EN and INL_CALI_EN are all 1 for exactly T_INL cycles, then TRACK.
- TRACK: all three enables are 1 and LOCKED=1.
  - LOCK_CNT consecutive cycles with |PHE_NORM| >= UNLOCK_THR cause: LOCKED falls, RELOCK_CNT increments (saturating at 255), state goes to PSYNC.
  - INL_CALI_EN stays 1 in TRACK.
- FAULT: DSM_EN=1 and the other enables are 0. Exits on START, on an accepted FCW, or on ABORT.
- ABORT: the next state is IDLE with all enables 0. FCW_FOD is held.
- Priority when events coincide: ABORT > accepted FCW > START.
  - FCW_VALID in TRACK forces a retune through LOAD; LOCKED falls with the transition.
- Magnitude rule: |PHE_NORM| is the two's-complement absolute value. -2^(WF-1) saturates to 2^(WF-1)-1. Comparisons use unsigned WF-bit values.
- The consecutive-cycle counter resets on any non-qualifying sample and on every state change.

## Timing
- Moore outputs are decoded from the registered state; FCW_FOD is a register. No input reaches an output combinationally.
- FCW_READY is decoded from the state only.
- Accept at edge k: FCW_FOD is new and DSM_EN=0 during cycle k+1 (LOAD). DSM_EN=1 from edge k+1 for T_SETTLE cycles.
- Lock qualification: if the LOCK_CNT-th qualifying sample is captured at edge m, the state is INL after edge m, and INL_CALI_EN is high from that edge.
- ERR_RANGE is registered and asserts in the cycle after the rejecting edge.
- RST asserted at any time, including mid-sequence: immediately sets all outputs to their reset values and the state to IDLE. Counters clear.

## Structure
- Package fod_ctrl_pkg holds:
  - the state enum and encodings,
  - WI and WF defaults,
  - the FCW reset constant {6'd4, 16'd0},
  - the minimum integer value 4.
- Sub-module fod_lock_det contains the |PHE_NORM| magnitude logic, the threshold compare and the consecutive counter. Inputs are threshold, polarity (below/above), enable and clear; output is a one-cycle hit pulse. It is instantiated once; the threshold and polarity are muxed by state.
- The timers (WARM, PSYNC timeout, INL) share one 16-bit down-counter that is loaded on state entry.

## Test plan
- Bench parameters: T_SETTLE=16, T_PSYNC_MAX=1000, T_INL=32, LOCK_CNT=8, LOCK_THR=64, UNLOCK_THR=512.
- Reset then FCW_IN={6'd10, 16'h8000} with PHE_NORM=0 -> LOAD for 1 cycle with DSM_EN=0, WARM for 16 cycles, lock after 8 cycles, INL for 32 cycles, then TRACK with LOCKED=1 and FCW_FOD=0x0A8000.
- FCW_IN integer part = 3 offered in IDLE -> ERR_RANGE pulses once, FCW_FOD stays 0x040000, STATE stays 0.
- In PSYNC, PHE_NORM alternates between 10 and 100 -> never locks; after 1000 cycles the state is FAULT, TIMEOUT=1, PSYNC_EN=0; a following START clears TIMEOUT and enters LOAD.
- In TRACK, PHE_NORM=-600 for 8 cycles -> LOCKED falls, RELOCK_CNT=1, state PSYNC. Repeat with 7 cycles of -600 then 0 -> no unlock. PHE_NORM=16'h8000 counts as above threshold.
- In WARM, ABORT and FCW_VALID asserted together -> IDLE on the next cycle, all enables 0, FCW_FOD unchanged.
- RST pulsed while in INL -> all outputs return to reset values asynchronously, before the next clock edge; after release, START runs a full sequence with FCW {6'd4, 16'd0}.
